// File: rtl/axi_w_trace_capture.sv
// axi_w_trace_capture
// -------------------
// Passive capture unit for AXI W-channel traffic. Every accepted beat on an
// enabled channel, seen while capture is armed, is written into a shared FIFO
// together with its channel id and a free-running cycle timestamp. Capture is
// armed and stopped through a 64-bit event register value. Entries drain
// through a valid/ready stream. Beats that cannot be stored are counted in a
// saturating drop counter.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   en_i         per-channel capture enable mask
//   trigger_i    event register value (1 = arm, all-ones = stop, sticky)
//   w_data_i     W data, channel c at [c*DataWidth +: DataWidth]
//   w_strb_i     W strobes, channel c at [c*DataWidth/8 +: DataWidth/8]
//   w_valid_i    W valid per channel (observed only)
//   w_ready_i    W ready per channel (observed only)
//   out_valid_o  head entry valid (FIFO not empty)
//   out_ready_i  consumer ready; pop on out_valid_o & out_ready_i
//   out_data_o   head entry data
//   out_strb_o   head entry strobes
//   out_chan_o   head entry channel id
//   out_ts_o     head entry timestamp
//   drop_cnt_o   saturating count of dropped beats
//   state_o      0 = IDLE, 1 = CAPTURE, 2 = STOPPED
//   fill_o       FIFO occupancy
module axi_w_trace_capture #(
    parameter int unsigned NrChannels = 2,
    parameter int unsigned DataWidth  = 256,
    parameter int unsigned Depth      = 16,
    parameter int unsigned TsWidth    = 32,
    parameter int unsigned CntWidth   = 16,
    localparam int unsigned ChanW     = (NrChannels > 1) ? $clog2(NrChannels) : 1,
    localparam int unsigned StrbW     = DataWidth / 8,
    localparam int unsigned FillW     = $clog2(Depth) + 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NrChannels-1:0]            en_i,
    input  logic [63:0]                      trigger_i,
    input  logic [NrChannels*DataWidth-1:0]  w_data_i,
    input  logic [NrChannels*StrbW-1:0]      w_strb_i,
    input  logic [NrChannels-1:0]            w_valid_i,
    input  logic [NrChannels-1:0]            w_ready_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [DataWidth-1:0]             out_data_o,
    output logic [StrbW-1:0]                 out_strb_o,
    output logic [ChanW-1:0]                 out_chan_o,
    output logic [TsWidth-1:0]               out_ts_o,
    output logic [CntWidth-1:0]              drop_cnt_o,
    output logic [1:0]                       state_o,
    output logic [FillW-1:0]                 fill_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned DropW = $clog2(NrChannels + 1);
    localparam int unsigned SumW  = ((CntWidth > DropW) ? CntWidth : DropW) + 1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StStopped = 2'd2
    } state_e;

    state_e               state_q;
    logic [TsWidth-1:0]   ts_q;
    logic [AddrW-1:0]     wptr_q, rptr_q;
    logic [FillW-1:0]     fill_q, fill_d;
    logic [CntWidth-1:0]  drop_q, drop_d;

    // FIFO storage is never reset; out_* are gated by out_valid_o instead.
    logic [DataWidth-1:0] mem_data [Depth];
    logic [StrbW-1:0]     mem_strb [Depth];
    logic [ChanW-1:0]     mem_chan [Depth];
    logic [TsWidth-1:0]   mem_ts   [Depth];

    logic [NrChannels-1:0] beat;
    logic [ChanW-1:0]      win_chan;
    logic [DataWidth-1:0]  win_data;
    logic [StrbW-1:0]      win_strb;
    logic [DropW-1:0]      n_beats;
    logic [DropW-1:0]      n_drop;
    logic                  push_req;
    logic                  push;
    logic                  pop;

    // Saturating add of this cycle's drops onto the counter.
    function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] a,
                                                    input logic [DropW-1:0]    b);
        logic [SumW-1:0] s;
        s = SumW'(a) + SumW'(b);
        if (s > SumW'({CntWidth{1'b1}})) begin
            return {CntWidth{1'b1}};
        end
        return CntWidth'(s);
    endfunction

    // Beat qualification uses the registered state, so the cycle in which the
    // arming trigger is first seen never captures.
    always_comb begin
        for (int c = 0; c < int'(NrChannels); c++) begin
            beat[c] = w_valid_i[c] & w_ready_i[c] & en_i[c] & (state_q == StCapture);
        end
    end

    // Lowest channel index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        win_chan = '0;
        win_data = '0;
        win_strb = '0;
        n_beats  = '0;
        for (int c = int'(NrChannels) - 1; c >= 0; c--) begin
            if (beat[c]) begin
                win_chan = ChanW'(c);
                win_data = w_data_i[c*DataWidth +: DataWidth];
                win_strb = w_strb_i[c*StrbW +: StrbW];
                n_beats  = n_beats + DropW'(1);
            end
        end
    end

    assign out_valid_o = (fill_q != '0);
    assign pop         = out_valid_o & out_ready_i;
    assign push_req    = |beat;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push        = push_req & ((fill_q != FillW'(Depth)) | pop);
    assign n_drop      = n_beats - DropW'(push);
    assign drop_d      = sat_add(drop_q, n_drop);

    always_comb begin
        fill_d = fill_q;
        case ({push, pop})
            2'b10:   fill_d = fill_q + FillW'(1);
            2'b01:   fill_d = fill_q - FillW'(1);
            default: fill_d = fill_q;
        endcase
    end

    // Control FSM: stop has top priority and is sticky until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else if (trigger_i == 64'hFFFF_FFFF_FFFF_FFFF) begin
            state_q <= StStopped;
        end else begin
            case (state_q)
                StIdle:    if (trigger_i == 64'h1) state_q <= StCapture;
                StCapture: state_q <= StCapture;
                StStopped: state_q <= StStopped;
                default:   state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q   <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
            drop_q <= '0;
        end else begin
            ts_q   <= ts_q + TsWidth'(1);
            fill_q <= fill_d;
            drop_q <= drop_d;
            if (push) wptr_q <= wptr_q + AddrW'(1);
            if (pop)  rptr_q <= rptr_q + AddrW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data[wptr_q] <= win_data;
            mem_strb[wptr_q] <= win_strb;
            mem_chan[wptr_q] <= win_chan;
            mem_ts[wptr_q]   <= ts_q;
        end
    end

    assign out_data_o = out_valid_o ? mem_data[rptr_q] : '0;
    assign out_strb_o = out_valid_o ? mem_strb[rptr_q] : '0;
    assign out_chan_o = out_valid_o ? mem_chan[rptr_q] : '0;
    assign out_ts_o   = out_valid_o ? mem_ts[rptr_q]   : '0;
    assign drop_cnt_o = drop_q;
    assign state_o    = state_q;
    assign fill_o     = fill_q;

endmodule
